// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transceiver with independent TX and RX paths.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   tx             serial output, idle high
//   tx_data/valid  byte to send, handshaked by tx_ready (high only while TX is idle)
//   rx             serial input, asynchronous to clk, idle high
//   rx_data/valid  last good received byte, held until rx_valid && rx_ready
//   rx_frame_err, rx_parity_err, rx_overrun  one-cycle error pulses
module uart_xcvr #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]  DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]  StopLast = 4'(STOP_BITS - 1);

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_armed_q;  // holds tx_ready low until the first edge after reset
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BitLast);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_bit_end || tx_state_q == TxIdle) ? '0 : tx_cnt_q + 16'd1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx         = 1'b1;
    tx_ready   = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_ready = tx_armed_q;
        if (tx_armed_q && tx_valid) begin
          tx_state_d = TxStart;
          tx_shift_d = tx_data;
          tx_par_d   = ^tx_data ^ PARITY_ODD;
        end
      end
      TxStart: begin
        tx = 1'b0;
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_idx_d   = '0;
        end
      end
      TxData: begin
        tx = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = tx_idx_q + 4'd1;
          if (tx_idx_q == DataLast) begin
            tx_state_d = PARITY_EN ? TxParity : TxStop;
            tx_idx_d   = '0;
          end
        end
      end
      TxParity: begin
        tx = tx_par_q;
        if (tx_bit_end) tx_state_d = TxStop;
      end
      TxStop: begin
        if (tx_bit_end) begin
          tx_idx_d = tx_idx_q + 4'd1;
          if (tx_idx_q == StopLast) tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_armed_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_armed_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitIdle
  } rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  logic [15:0]          rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
  logic                 rx_sample;

  assign rx_s      = rx_sync_q[1];
  // First sample lands mid start bit; every later one is a full bit period on.
  assign rx_sample = (rx_state_q == RxStart) ? (rx_cnt_q == HalfLast) : (rx_cnt_q == BitLast);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = (rx_sample || rx_state_q == RxIdle) ? '0 : rx_cnt_q + 16'd1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    fe_d       = 1'b0;
    pe_d       = 1'b0;
    ov_d       = 1'b0;
    unique case (rx_state_q)
      // Idle is only ever entered with the line high, so a low level is a falling edge.
      RxIdle: if (!rx_s) rx_state_d = RxStart;
      RxStart: begin
        rx_perr_d = 1'b0;
        if (rx_sample) begin
          rx_state_d = rx_s ? RxIdle : RxData;
          rx_idx_d   = '0;
        end
      end
      RxData: begin
        if (rx_sample) begin
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          rx_idx_d   = rx_idx_q + 4'd1;
          if (rx_idx_q == DataLast) rx_state_d = PARITY_EN ? RxParity : RxStop;
        end
      end
      RxParity: begin
        if (rx_sample) begin
          rx_perr_d  = rx_s ^ (^rx_shift_q) ^ PARITY_ODD;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_sample) begin
          fe_d = !rx_s;
          pe_d = rx_perr_q;
          if (rx_s && !rx_perr_q) begin
            if (rx_valid_q && !rx_ready) begin
              ov_d = 1'b1;
            end else begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
            end
          end
          rx_state_d = rx_s ? RxIdle : RxWaitIdle;
        end
      end
      RxWaitIdle: if (rx_s) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      ov_q       <= ov_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = fe_q;
  assign rx_parity_err = pe_q;
  assign rx_overrun    = ov_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr: u_dut (8N1) is checked cycle by cycle against a queue model of the
// expected tx line, with loopback/bench-driven RX scoreboarded; u_par (8E1) covers parity.
module tb_uart_xcvr;
  localparam int Cpb = 16;

  logic clk, rst;
  logic lb, line, line2, dut_rx;
  logic tx, tx_valid, tx_ready, rx_valid, rx_ready, fe, pe, ov;
  logic [7:0] tx_data, rx_data;
  logic p_tx, p_tx_valid, p_tx_ready, p_rx_valid, p_rx_ready, p_fe, p_pe, p_ov;
  logic [7:0] p_tx_data, p_rx_data;

  int n_assert = 0, n_fail = 0, cyc = 0;
  int fe_n = 0, pe_n = 0, ov_n = 0, pfe_n = 0, ppe_n = 0, p_fe_cyc = 0, p_pe_cyc = 0;

  assign dut_rx = lb ? tx : line;

  uart_xcvr u_dut (
    .clk(clk), .rst(rst), .rx(dut_rx), .tx(tx), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(fe), .rx_parity_err(pe), .rx_overrun(ov)
  );

  uart_xcvr #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)
  ) u_par (
    .clk(clk), .rst(rst), .rx(line2), .tx(p_tx), .tx_data(p_tx_data), .tx_valid(p_tx_valid),
    .tx_ready(p_tx_ready), .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_ready(p_rx_ready),
    .rx_frame_err(p_fe), .rx_parity_err(p_pe), .rx_overrun(p_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // TX model: one queue entry per clock cycle of the expected tx line for the frame in flight.
  logic exp_tx_q[$];
  logic [9:0] tx_frame;
  logic dummy;
  bit oor;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_tx_q.delete();
      oor = 1'b0;
    end else begin
      if (exp_tx_q.size() > 0) dummy = exp_tx_q.pop_front();
      else if (oor && tx_valid) begin
        tx_frame = {1'b1, tx_data, 1'b0};
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < Cpb; c++) exp_tx_q.push_back(tx_frame[b]);
      end
      oor = 1'b1;
    end
  end

  logic [7:0] exp_rx_q[$], exp_prx_q[$];
  logic hold, p_hold, prev_fe, prev_pe, prev_ov;
  logic [7:0] hold_data, p_hold_data;

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_tx", tx, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_err", {fe, pe, ov, p_fe, p_pe, p_ov}, 0);
      check("rst_p_tx_ready", p_tx_ready, 0);
      check("rst_p_rx_valid", p_rx_valid, 0);
      hold = 0; p_hold = 0; prev_fe = 0; prev_pe = 0; prev_ov = 0;
    end else begin
      check("tx_line", tx, exp_tx_q.size() > 0 ? exp_tx_q[0] : 1'b1);
      check("tx_ready", tx_ready, oor && exp_tx_q.size() == 0);
      if (hold) begin
        check("rx_hold_valid", rx_valid, 1);
        check("rx_hold_data", rx_data, hold_data);
      end
      if (p_hold) check("p_rx_hold_valid", p_rx_valid, 1);
      if (prev_fe) check("fe_pulse_width", fe, 0);
      if (prev_pe) check("pe_pulse_width", pe, 0);
      if (prev_ov) check("ov_pulse_width", ov, 0);
      if (rx_valid && rx_ready) begin
        if (exp_rx_q.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL rx_unexpected: got %0h expected no byte", rx_data);
        end else check("rx_data", rx_data, exp_rx_q.pop_front());
      end
      if (p_rx_valid && p_rx_ready) begin
        if (exp_prx_q.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL p_rx_unexpected: got %0h expected no byte", p_rx_data);
        end else check("p_rx_data", p_rx_data, exp_prx_q.pop_front());
      end
      if (fe) fe_n++;
      if (pe) pe_n++;
      if (ov) ov_n++;
      if (p_fe) begin pfe_n++; p_fe_cyc = cyc; end
      if (p_pe) begin ppe_n++; p_pe_cyc = cyc; end
      hold = rx_valid && !rx_ready;   hold_data = rx_data;
      p_hold = p_rx_valid && !p_rx_ready; p_hold_data = p_rx_data;
      prev_fe = fe; prev_pe = pe; prev_ov = ov;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input bit sel, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    while (!(sel ? p_tx_ready : tx_ready) && w < 2000) begin @(negedge clk); w++; end
    check("tx_ready_wait", sel ? p_tx_ready : tx_ready, 1);
    if (sel) begin p_tx_data = b; p_tx_valid = 1'b1; end
    else begin tx_data = b; tx_valid = 1'b1; end
    @(posedge clk); #1;
    p_tx_valid = 1'b0; tx_valid = 1'b0;
  endtask

  // Sends b and records busy cycle count plus the mid-bit value of each bit.
  task automatic send_byte(input bit sel, input logic [7:0] b, output int cnt,
                           output logic [15:0] bits);
    start_tx(sel, b);
    cnt = 0; bits = '0;
    while (cnt < 1000) begin
      @(negedge clk);
      if (sel ? p_tx_ready : tx_ready) break;
      if (cnt % Cpb == Cpb / 2) bits[cnt / Cpb] = sel ? p_tx : tx;
      cnt++;
      if (sel) p_tx_data = 8'($urandom); else tx_data = 8'($urandom);
    end
  endtask

  task automatic drive_frame(input bit sel, input logic [7:0] d, input bit pen, input bit pbit,
                             input bit stopv);
    logic [15:0] bits;
    int n = 0;
    bits = '0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (pen) begin bits[n] = pbit; n++; end
    bits[n] = stopv; n++;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (sel) line2 = bits[i]; else line = bits[i];
      idle(Cpb);
    end
  endtask

  task automatic wait_drain(input bit sel);
    int w = 0;
    while ((sel ? exp_prx_q.size() : exp_rx_q.size()) != 0 && w < 400) begin
      @(negedge clk); w++;
    end
    check("rx_drain", sel ? exp_prx_q.size() : exp_rx_q.size(), 0);
  endtask

  initial begin
    int cnt;
    logic [15:0] bits;
    logic [7:0] b;
    logic [7:0] fixed [3];
    fixed[0] = 8'h00; fixed[1] = 8'hFF; fixed[2] = 8'h3C;
    rst = 1'b0; lb = 1'b0; line = 1'b1; line2 = 1'b1;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;
    p_tx_valid = 1'b0; p_tx_data = '0; p_rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("ready_before_first_edge", tx_ready, 0);
    @(posedge clk); #1;
    check("ready_after_first_edge", tx_ready, 1);
    check("p_ready_after_first_edge", p_tx_ready, 1);

    // 0xA5, 8N1
    send_byte(0, 8'hA5, cnt, bits);
    check("a5_busy_cycles", cnt, 160);
    check("a5_bits", bits[9:0], 10'h34A);

    // Loopback: fixed patterns then random bytes with random gaps
    lb = 1'b1;
    for (int i = 0; i < 11; i++) begin
      b = (i < 3) ? fixed[i] : 8'($urandom);
      exp_rx_q.push_back(b);
      send_byte(0, b, cnt, bits);
      check("lb_bits", bits[9:0], {1'b1, b, 1'b0});
      idle($urandom_range(0, 20));
    end
    wait_drain(0);
    check("lb_no_errors", fe_n + pe_n + ov_n, 0);

    // Parity TX: 0x07 even parity -> parity bit 1, 11 bits
    send_byte(1, 8'h07, cnt, bits);
    check("p07_busy_cycles", cnt, 176);
    check("p07_bits", bits[10:0], 11'h60E);

    // Parity RX: wrong parity bit
    drive_frame(1, 8'h07, 1, 0, 1);
    idle(20);
    check("p_parity_err_count", ppe_n, 1);
    check("p_frame_err_none", pfe_n, 0);
    check("p_rx_valid_low", p_rx_valid, 0);
    // Wrong parity and bad stop together; line held low then released
    drive_frame(1, 8'h07, 1, 0, 0);
    idle(20);
    line2 = 1'b1;
    idle(20);
    check("p_both_parity", ppe_n, 2);
    check("p_both_frame", pfe_n, 1);
    check("p_both_same_cycle", p_fe_cyc, p_pe_cyc);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_prx_q.push_back(b);
      drive_frame(1, b, 1, ^b, 1);
      idle($urandom_range(1, 10));
    end
    wait_drain(1);

    // Framing error, line held low, then a good frame
    lb = 1'b0;
    drive_frame(0, 8'h55, 0, 0, 0);
    idle(30);
    line = 1'b1;
    idle(20);
    check("fe_count", fe_n, 1);
    exp_rx_q.push_back(8'h12);
    drive_frame(0, 8'h12, 0, 0, 1);
    idle(5);
    wait_drain(0);

    // Overrun: two frames while the consumer stalls
    rx_ready = 1'b0;
    exp_rx_q.push_back(8'h11);
    drive_frame(0, 8'h11, 0, 0, 1);
    idle(20);
    drive_frame(0, 8'h22, 0, 0, 1);
    idle(20);
    check("ov_count", ov_n, 1);
    check("ov_rx_valid", rx_valid, 1);
    check("ov_rx_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_drain(0);
    // 4-cycle glitch must produce nothing
    line = 1'b0;
    idle(4);
    line = 1'b1;
    idle(40);
    check("glitch_rx_valid", rx_valid, 0);
    check("glitch_errors", fe_n + pe_n + ov_n, 2);

    // Reset in the middle of a TX frame
    start_tx(0, 8'hC3);
    repeat (49) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset_tx", tx, 1);
    check("async_reset_ready", tx_ready, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    lb = 1'b1;
    exp_rx_q.push_back(8'h5A);
    send_byte(0, 8'h5A, cnt, bits);
    check("5a_busy_cycles", cnt, 160);
    check("5a_bits", bits[9:0], 10'h2B4);
    wait_drain(0);
    check("final_pe_count", pe_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 Parameter CLKS_PER_BIT, 16, clk cycles per bit; legal range is 4..65535.
REQ-002 Parameter DATA_BITS, 8, data bits per frame; legal range is 5..8.
REQ-003 Parameter PARITY_EN, 0, 1 appends/checks one parity bit.
REQ-004 Parameter PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous assert, active-low reset (0 = reset); the only reset.
REQ-008 rx  in  1  serial input, asynchronous to clk, idle high.
REQ-009 tx  out  1  serial output, idle high.
REQ-010 tx_data  in  DATA_BITS  byte to transmit.
REQ-011 tx_valid  in  1  tx_data valid.
REQ-012 tx_ready  out  1  transmitter can accept.
REQ-013 rx_data  out  DATA_BITS  last received byte.
REQ-014 rx_valid  out  1  rx_data holds an unread byte.
REQ-015 rx_ready  in  1  consumer accepts rx_data.
REQ-016 rx_frame_err, rx_parity_err, rx_overrun  out  1 each  one-cycle error pulses.

Function
REQ-017 TX FSM states are IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE.
REQ-018 TX accepts when tx_valid&&tx_ready, latches tx_data, and drives tx=0 starting the next cycle.
REQ-019 TX holds each bit exactly CLKS_PER_BIT cycles, in order: start(0), data LSB first, parity if PARITY_EN, STOP_BITS stop(1).
REQ-020 TX frame occupies CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles; tx_ready reasserts on the cycle after the last stop bit ends.
REQ-021 Parity bit: XOR of data bits, inverted when PARITY_ODD=1.
REQ-022 Changes to tx_data while tx_ready=0 have no effect on the frame in flight.
REQ-023 rx passes through a 2-flop synchroniser; all RX decisions use the synchronised value.
REQ-024 RX FSM states are IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; a falling edge in IDLE enters START.
REQ-025 RX samples at CLKS_PER_BIT/2 (integer divide) into each bit, then every CLKS_PER_BIT cycles.
REQ-026 Start sample =1: false start, return to IDLE, no output, no error.
REQ-027 RX samples only the first stop bit; on good stop with no parity error, RX loads rx_data and sets rx_valid on the next cycle.
REQ-028 rx_valid stays high until the cycle after rx_valid&&rx_ready sampled high.
REQ-029 Frame completes while rx_valid=1 and rx_ready=0: pulse rx_overrun, discard new byte, retain rx_data.
REQ-030 Frame completes in the same cycle that rx_valid&&rx_ready: no overrun; new byte loads and rx_valid stays 1.
REQ-031 Parity mismatch: pulse rx_parity_err at stop sample, discard byte.
REQ-032 Stop sample =0: pulse rx_frame_err, discard byte, enter WAIT_IDLE until synchronised rx=1, then IDLE.
REQ-033 Simultaneous parity and framing errors: both pulses assert in the same cycle.
REQ-034 TX and RX are fully independent; simultaneous operation is required.

Reset
REQ-035 While rst=0: tx=1, tx_ready=0, rx_valid=0, rx_data=0, all error pulses 0, both FSMs IDLE, counters 0, synchroniser flops 1.
REQ-036 tx_ready rises on the first clk edge after rst deasserts.
REQ-037 Reset mid-frame aborts immediately; tx returns to 1 asynchronously and the partial frame is never resumed.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-038 PARITY_EN=0, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 at 16 cycles each; tx_ready low exactly 160 cycles.
REQ-039 Loopback tx->rx with 0x00, 0xFF, 0x3C -> each appears on rx_data with rx_valid and no error pulses.
REQ-040 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 176 cycles; RX fed parity 0 -> rx_parity_err pulse, rx_valid stays 0.
REQ-041 RX frame 0x55 with stop bit driven 0 -> rx_frame_err pulse; line held 0 then released -> next frame 0x12 received correctly.
REQ-042 Two frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x11, one rx_overrun pulse; 4-cycle low glitch on rx -> no output.
REQ-043 rst=0 at cycle 50 of a TX frame -> tx=1 immediately; after release, new 0x5A frame is transmitted correctly.
